// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu with HI/LO
// ownership, plus mfhi/mflo/mthi/mtlo service for the execute stage.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_MD_Valid,
  input  logic [3:0]  E_MD_Op,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  output logic [31:0] E_MD_Out,
  output logic        E_MD_Busy,
  output logic        E_MD_Hold,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // Signed divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // and the remainder follows the dividend's sign. Returns {rem, quo}.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm, q, r;
    am = a[31] ? (~a + 32'd1) : a;
    bm = b[31] ? (~b + 32'd1) : b;
    if (bm == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      phi_q, phi_d, plo_q, plo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic signed [63:0] rs_sx, rt_sx, prod_s;
  logic        [63:0] prod_u, quo_rem_s, quo_rem_u;
  logic               busy, md_op;

  assign rs_sx     = $signed({{32{E_RS[31]}}, E_RS});
  assign rt_sx     = $signed({{32{E_RT[31]}}, E_RT});
  assign prod_s    = rs_sx * rt_sx;
  assign prod_u    = {32'd0, E_RS} * {32'd0, E_RT};
  assign quo_rem_s = div_signed(E_RS, E_RT);
  assign quo_rem_u = div_unsigned(E_RS, E_RT);

  assign busy      = (cnt_q != '0);
  assign md_op     = (E_MD_Op >= OP_MULT) && (E_MD_Op <= OP_DIVU);
  assign E_MD_Busy = busy;
  assign E_MD_Hold = busy | (E_MD_Valid & md_op);
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_comb begin
    E_MD_Out = 32'd0;
    if (E_MD_Op == OP_MFHI)      E_MD_Out = hi_q;
    else if (E_MD_Op == OP_MFLO) E_MD_Out = lo_q;
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (busy) begin
      // Requests arriving while busy are dropped; the hazard unit prevents them.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !dz_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (E_MD_Valid) begin
      case (E_MD_Op)
        OP_MULT: begin
          phi_d = prod_s[63:32];
          plo_d = prod_s[31:0];
          cnt_d = MULT_LD;
          dz_d  = 1'b0;
        end
        OP_MULTU: begin
          phi_d = prod_u[63:32];
          plo_d = prod_u[31:0];
          cnt_d = MULT_LD;
          dz_d  = 1'b0;
        end
        OP_DIV: begin
          phi_d = quo_rem_s[63:32];
          plo_d = quo_rem_s[31:0];
          cnt_d = DIV_LD;
          dz_d  = (E_RT == 32'd0);
        end
        OP_DIVU: begin
          phi_d = quo_rem_u[63:32];
          plo_d = quo_rem_u[31:0];
          cnt_d = DIV_LD;
          dz_d  = (E_RT == 32'd0);
        end
        OP_MTHI: hi_d = E_RS;
        OP_MTLO: lo_d = E_RS;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      phi_q <= 32'd0;
      plo_q <= 32'd0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: arithmetic reference model checked every cycle, plus
// directed vectors with literal expected HI/LO/busy values.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        E_MD_Valid = 1'b0;
  logic [3:0]  E_MD_Op = 4'd0;
  logic [31:0] E_RS = 32'd0;
  logic [31:0] E_RT = 32'd0;
  logic [31:0] E_MD_Out, HI, LO;
  logic        E_MD_Busy, E_MD_Hold;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MD_Valid(E_MD_Valid),
    .E_MD_Op   (E_MD_Op),
    .E_RS      (E_RS),
    .E_RT      (E_RT),
    .E_MD_Out  (E_MD_Out),
    .E_MD_Busy (E_MD_Busy),
    .E_MD_Hold (E_MD_Hold),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  // Reference model: plain 64-bit integer arithmetic and a countdown to writeback.
  longint      a_s, b_s, a_u, b_u;
  logic [63:0] r_mul_s, r_mul_u, r_div_s, r_div_u;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          m_left = 0;
  bit          m_dz = 0;

  always_comb begin
    a_s = longint'($signed(E_RS));
    b_s = longint'($signed(E_RT));
    a_u = longint'(E_RS);
    b_u = longint'(E_RT);
    r_mul_s = 64'(a_s * b_s);
    r_mul_u = 64'(a_u * b_u);
    r_div_s = 64'd0;
    r_div_u = 64'd0;
    if (E_RT != 32'd0) begin
      r_div_s = {32'(a_s % b_s), 32'(a_s / b_s)};
      r_div_u = {32'(a_u % b_u), 32'(a_u / b_u)};
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 0; m_lo <= 0; p_hi <= 0; p_lo <= 0; m_left <= 0; m_dz <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && !m_dz) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (E_MD_Valid) begin
      case (E_MD_Op)
        4'd1: begin p_hi <= r_mul_s[63:32]; p_lo <= r_mul_s[31:0]; m_left <= MULT_N; m_dz <= 0; end
        4'd2: begin p_hi <= r_mul_u[63:32]; p_lo <= r_mul_u[31:0]; m_left <= MULT_N; m_dz <= 0; end
        4'd3: begin p_hi <= r_div_s[63:32]; p_lo <= r_div_s[31:0]; m_left <= DIV_N; m_dz <= (E_RT == 0); end
        4'd4: begin p_hi <= r_div_u[63:32]; p_lo <= r_div_u[31:0]; m_left <= DIV_N; m_dz <= (E_RT == 0); end
        4'd7: m_hi <= E_RS;
        4'd8: m_lo <= E_RS;
        default: ;
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_out;
  logic        exp_busy, exp_hold;
  always_comb begin
    exp_out  = (E_MD_Op == 4'd5) ? m_hi : (E_MD_Op == 4'd6) ? m_lo : 32'd0;
    exp_busy = (m_left != 0);
    exp_hold = exp_busy | (E_MD_Valid & (E_MD_Op >= 4'd1) & (E_MD_Op <= 4'd4));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_out",  E_MD_Out, exp_out);
      cmp("model_busy", {31'd0, E_MD_Busy}, {31'd0, exp_busy});
      cmp("model_hold", {31'd0, E_MD_Hold}, {31'd0, exp_hold});
      cmp("model_hi",   HI, m_hi);
      cmp("model_lo",   LO, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    E_MD_Valid = v;
    E_MD_Op    = op;
    E_RS       = rs;
    E_RT       = rt;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int nbusy);
    drive(1'b1, op, rs, rt);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    nbusy = 0;
    while (E_MD_Busy && nbusy < 40) begin
      nbusy++;
      tick();
    end
  endtask

  int nb;

  initial begin
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) tick();
    chk_en = 1'b1;
    drive(1'b0, 4'd1, 32'd1, 32'd1);
    #1;
    cmp("rst_hi", HI, 32'd0);
    cmp("rst_lo", LO, 32'd0);
    cmp("rst_busy", {31'd0, E_MD_Busy}, 32'd0);
    cmp("rst_hold", {31'd0, E_MD_Hold}, 32'd0);
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    cmp("rst_out", E_MD_Out, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    issue(4'd1, 32'hFFFFFFFE, 32'd3, nb);
    cmp("mult_busy_cycles", 32'(nb), 32'd5);
    cmp("mult_hi", HI, 32'hFFFFFFFF);
    cmp("mult_lo", LO, 32'hFFFFFFFA);

    issue(4'd2, 32'hFFFFFFFE, 32'd3, nb);
    cmp("multu_busy_cycles", 32'(nb), 32'd5);
    cmp("multu_hi", HI, 32'h00000002);
    cmp("multu_lo", LO, 32'hFFFFFFFA);

    issue(4'd3, 32'hFFFFFFF9, 32'd2, nb);
    cmp("div_busy_cycles", 32'(nb), 32'd10);
    cmp("div_hi", HI, 32'hFFFFFFFF);
    cmp("div_lo", LO, 32'hFFFFFFFD);

    issue(4'd4, 32'd7, 32'd2, nb);
    cmp("divu_hi", HI, 32'd1);
    cmp("divu_lo", LO, 32'd3);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
    cmp("div_ovf_hi", HI, 32'd0);
    cmp("div_ovf_lo", LO, 32'h80000000);

    drive(1'b1, 4'd7, 32'h1234, 32'd0);
    #1;
    cmp("mthi_no_hold", {31'd0, E_MD_Hold}, 32'd0);
    tick();
    drive(1'b1, 4'd5, 32'd0, 32'd0);
    #1;
    cmp("mthi_visible_hi", HI, 32'h1234);
    cmp("mfhi_out", E_MD_Out, 32'h1234);
    cmp("mthi_no_busy", {31'd0, E_MD_Busy}, 32'd0);
    issue(4'd4, 32'd99, 32'd0, nb);
    cmp("divz_busy_cycles", 32'(nb), 32'd10);
    cmp("divz_hi_kept", HI, 32'h1234);
    cmp("divz_lo_kept", LO, 32'h80000000);

    // Requests inside the busy window must not disturb the running mult.
    drive(1'b1, 4'd1, 32'd6, 32'd7);
    tick();
    drive(1'b1, 4'd6, 32'd0, 32'd0);
    #1;
    cmp("mflo_during_busy", E_MD_Out, 32'h80000000);
    tick();
    drive(1'b1, 4'd8, 32'hDEAD, 32'd0);
    tick();
    drive(1'b1, 4'd1, 32'd9, 32'd9);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    nb = 0;
    while (E_MD_Busy && nb < 40) begin
      nb++;
      tick();
    end
    cmp("ignored_ops_hi", HI, 32'd0);
    cmp("ignored_ops_lo", LO, 32'd42);
    issue(4'd1, 32'd3, 32'd4, nb);
    cmp("b2b_busy_cycles", 32'(nb), 32'd5);
    cmp("b2b_lo", LO, 32'd12);

    drive(1'b0, 4'd3, 32'd10, 32'd2);
    #1;
    cmp("hold_invalid", {31'd0, E_MD_Hold}, 32'd0);
    tick();
    cmp("no_start_invalid", {31'd0, E_MD_Busy}, 32'd0);
    drive(1'b1, 4'd3, 32'd10, 32'd2);
    #1;
    cmp("hold_start", {31'd0, E_MD_Hold}, 32'd1);
    cmp("busy_start", {31'd0, E_MD_Busy}, 32'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    cmp("busy_after_start", {31'd0, E_MD_Busy}, 32'd1);
    nb = 0;
    while (E_MD_Busy && nb < 40) begin
      nb++;
      tick();
    end
    cmp("div10_lo", LO, 32'd5);

    drive(1'b1, 4'd1, 32'd5, 32'd5);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    cmp("midrst_hi", HI, 32'd0);
    cmp("midrst_lo", LO, 32'd0);
    cmp("midrst_busy", {31'd0, E_MD_Busy}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (12) tick();
    drive(1'b1, 4'd6, 32'd0, 32'd0);
    #1;
    cmp("postrst_mflo", E_MD_Out, 32'd0);
    cmp("postrst_hi", HI, 32'd0);
    tick();
    drive(1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It runs mult/multu/div/divu as multi-cycle operations on forwarded E-stage operands and holds the architectural HI/LO registers. It also serves mfhi/mflo/mthi/mtlo. Its read result feeds the E-stage result mux that drives the E→M pipeline register. Its busy/hold outputs feed the hazard unit, which stalls D-stage multiply/divide instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  in  1  pipeline clock, rising edge
- reset  in  1  one clock; reset is asynchronous and active-low
- E_MD_Valid  in  1  E-stage instruction is valid and not being cleared; ops act only when 1
- E_MD_Op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- E_RS  in  32  forwarded rs operand
- E_RT  in  32  forwarded rt operand
- E_MD_Out  out  32  HI for mfhi, LO for mflo, else 0; combinational
- E_MD_Busy  out  1  operation in flight (counter ≠ 0)
- E_MD_Hold  out  1  E_MD_Busy | (E_MD_Valid & op∈1..4); combinational, for the hazard unit
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

## Operation
- State: HI, LO, pending result regs P_HI/P_LO (32 each), down-counter CNT (4 bits min, sized for max parameter), flag DZ (divide by zero).
- Start (Valid & op 1–4 & CNT==0) at an edge:
  - P_HI/P_LO computed from E_RS/E_RT and registered.
  - CNT ← MULT_CYCLES or DIV_CYCLES.
  - DZ ← (op div/divu & E_RT==0).
- mult: signed 64-bit product of rs×rt. multu: unsigned product. P_HI = [63:32], P_LO = [31:0].
- div: signed, quotient truncated toward zero. P_LO = quotient; P_HI = remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Each edge with CNT≠0: CNT ← CNT−1. On the edge where CNT goes 1→0, HI/LO ← P_HI/P_LO, unless DZ=1, in which case HI/LO are unchanged.
- mthi/mtlo (Valid, CNT==0): HI←rs or LO←rs at the edge; no busy.
- Any op presented while CNT≠0 is ignored. The hazard unit guarantees this does not happen. mfhi/mflo during busy return the old (pre-completion) HI/LO.
- Valid=0: no state change apart from the counter continuing.
- Reset (async, low):
  - HI=LO=P_HI=P_LO=0, CNT=0, DZ=0.
  - Busy=0, Hold=0 for Valid=0, E_MD_Out=0 for op none.
  - An in-flight operation is discarded immediately; no HI/LO writeback after reset release.

## Timing
- Start sampled at edge T0. Busy=1 in the cycles after T0, T1, …, up to the edge T(N−1), with N = MULT_CYCLES/DIV_CYCLES. HI/LO update at edge TN, and Busy=0 in the cycle following TN.
- Hold=1 in the start cycle itself (Busy still 0) and for every busy cycle.
- A new start is accepted in the first cycle Busy=0, back-to-back with completion.
- mfhi/mflo issued in the cycle after completion see the new value. E_MD_Out has zero latency (combinational from HI/LO).
- mthi/mtlo are visible on E_MD_Out/HI/LO in the cycle after their edge.
- Reset assertion is asynchronous. Release is taken at the next edge; first start is possible at the first edge with reset high.

## Test plan
- mult rs=0xFFFFFFFE, rt=3 at T0 → Busy high 5 cycles; at T5 HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu → HI=0x00000002, LO=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (−7), rt=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1. 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x1234, then divu rt=0 → Busy 10 cycles, HI stays 0x1234, LO unchanged.
- Busy-window checks:
  - mflo during busy returns the old LO.
  - mtlo/mult presented mid-busy are ignored: HI/LO equal the first op's result.
  - A mult issued in the completion+1 cycle starts normally.
- Hold check: Valid=1, op=div in the start cycle → Hold=1, Busy=0. Same op with Valid=0 → no start, Hold=0.
- Reset low at busy cycle 3 of mult 5×5 → HI=LO=0, Busy=0 immediately; after release no writeback occurs, and mflo → 0.
